// File: rtl/uart_reg_master.sv
// ============================================================================
// Module      : uart_reg_master
// Description : 8N1 UART receiver driving a small command parser that issues
//               register-file write (A5 addr data) and read (5A addr) strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_reg_master #(
    parameter int CLKS_PER_BIT = 217,
    parameter int TIMEOUT_CLKS = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_UART_RX,
    output logic       o_write_en,
    output logic [4:0] o_write_addr,
    output logic [7:0] o_write_data,
    output logic       o_read_en,
    output logic [4:0] o_read_addr,
    output logic       o_Frame_Error,
    output logic       o_Cmd_Error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0]  C_TIMEOUT   = TO_W'(TIMEOUT_CLKS);
    localparam logic [7:0]       C_HDR_WRITE = 8'hA5;
    localparam logic [7:0]       C_HDR_READ  = 8'h5A;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {CMD_IDLE, CMD_WADDR, CMD_WDATA, CMD_RADDR} cmd_state_t;

    // ---------------- receiver state ----------------
    logic             r_rx_meta, r_rx_sync;
    rx_state_t        r_rx_state, w_rx_next;
    logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_next;
    logic [2:0]       r_bit_idx, w_bit_idx_next;
    logic [7:0]       r_shift, w_shift_next;
    logic             r_stop_hold, w_stop_hold_next;
    logic             w_byte_valid, w_frame_err;
    logic             r_frame_error;

    // ---------------- parser state ----------------
    cmd_state_t       r_cmd_state, w_cmd_next;
    logic [4:0]       r_addr_latch, w_addr_latch_next;
    logic [TO_W-1:0]  r_idle_cnt;
    logic             w_timeout, w_addr_ok;
    logic             r_write_en, w_write_en_next;
    logic             r_read_en, w_read_en_next;
    logic [4:0]       r_write_addr, w_write_addr_next;
    logic [7:0]       r_write_data, w_write_data_next;
    logic [4:0]       r_read_addr, w_read_addr_next;
    logic             r_cmd_error, w_cmd_error_next;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_UART_RX;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Receiver state and bit-timing registers
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_rx_state    <= RX_IDLE;
            r_bit_cnt     <= '0;
            r_bit_idx     <= 3'd0;
            r_shift       <= 8'h00;
            r_stop_hold   <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_rx_state    <= w_rx_next;
            r_bit_cnt     <= w_bit_cnt_next;
            r_bit_idx     <= w_bit_idx_next;
            r_shift       <= w_shift_next;
            r_stop_hold   <= w_stop_hold_next;
            r_frame_error <= w_frame_err;
        end
    end

    // Receiver next-state: mid-bit sampling; a bad stop bit parks in RX_STOP until the line is high
    always_comb begin
        w_rx_next        = r_rx_state;
        w_bit_cnt_next   = r_bit_cnt;
        w_bit_idx_next   = r_bit_idx;
        w_shift_next     = r_shift;
        w_stop_hold_next = r_stop_hold;
        w_byte_valid     = 1'b0;
        w_frame_err      = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                w_bit_cnt_next = '0;
                w_bit_idx_next = 3'd0;
                if (!r_rx_sync) w_rx_next = RX_START;
            end
            RX_START: begin
                if (r_bit_cnt == C_HALF_LAST) begin
                    w_bit_cnt_next = '0;
                    w_rx_next      = r_rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_bit_cnt == C_BIT_LAST) begin
                    w_bit_cnt_next = '0;
                    w_shift_next   = {r_rx_sync, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) w_rx_next = RX_STOP;
                end else begin
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_stop_hold) begin
                    if (r_rx_sync) begin
                        w_stop_hold_next = 1'b0;
                        w_rx_next        = RX_IDLE;
                    end
                end else if (r_bit_cnt == C_BIT_LAST) begin
                    w_bit_cnt_next = '0;
                    if (r_rx_sync) begin
                        w_byte_valid = 1'b1;
                        w_rx_next    = RX_IDLE;
                    end else begin
                        w_frame_err      = 1'b1;
                        w_stop_hold_next = 1'b1;
                    end
                end else begin
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    assign w_timeout = (r_cmd_state != CMD_IDLE) && (r_idle_cnt == C_TIMEOUT);
    assign w_addr_ok = (r_shift[7:5] == 3'b000);

    // Inter-byte idle counter: saturates at the timeout value, held at zero when idle
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_idle_cnt <= '0;
        end else if (w_byte_valid || (r_cmd_state == CMD_IDLE)) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != C_TIMEOUT) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Parser state and registered outputs
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_cmd_state  <= CMD_IDLE;
            r_addr_latch <= 5'd0;
            r_write_en   <= 1'b0;
            r_read_en    <= 1'b0;
            r_write_addr <= 5'd0;
            r_write_data <= 8'h00;
            r_read_addr  <= 5'd0;
            r_cmd_error  <= 1'b0;
        end else begin
            r_cmd_state  <= w_cmd_next;
            r_addr_latch <= w_addr_latch_next;
            r_write_en   <= w_write_en_next;
            r_read_en    <= w_read_en_next;
            r_write_addr <= w_write_addr_next;
            r_write_data <= w_write_data_next;
            r_read_addr  <= w_read_addr_next;
            r_cmd_error  <= w_cmd_error_next;
        end
    end

    // Parser next-state: frame error beats a byte, a byte beats a timeout
    always_comb begin
        w_cmd_next        = r_cmd_state;
        w_addr_latch_next = r_addr_latch;
        w_write_en_next   = 1'b0;
        w_read_en_next    = 1'b0;
        w_write_addr_next = r_write_addr;
        w_write_data_next = r_write_data;
        w_read_addr_next  = r_read_addr;
        w_cmd_error_next  = 1'b0;
        if (w_frame_err) begin
            w_cmd_next = CMD_IDLE;
        end else if (w_byte_valid) begin
            unique case (r_cmd_state)
                CMD_IDLE: begin
                    if (r_shift == C_HDR_WRITE)     w_cmd_next = CMD_WADDR;
                    else if (r_shift == C_HDR_READ) w_cmd_next = CMD_RADDR;
                end
                CMD_WADDR: begin
                    if (w_addr_ok) begin
                        w_addr_latch_next = r_shift[4:0];
                        w_cmd_next        = CMD_WDATA;
                    end else begin
                        w_cmd_error_next = 1'b1;
                        w_cmd_next       = CMD_IDLE;
                    end
                end
                CMD_WDATA: begin
                    w_write_en_next   = 1'b1;
                    w_write_addr_next = r_addr_latch;
                    w_write_data_next = r_shift;
                    w_cmd_next        = CMD_IDLE;
                end
                CMD_RADDR: begin
                    if (w_addr_ok) begin
                        w_read_en_next   = 1'b1;
                        w_read_addr_next = r_shift[4:0];
                    end else begin
                        w_cmd_error_next = 1'b1;
                    end
                    w_cmd_next = CMD_IDLE;
                end
                default: w_cmd_next = CMD_IDLE;
            endcase
        end else if (w_timeout) begin
            w_cmd_error_next = 1'b1;
            w_cmd_next       = CMD_IDLE;
        end
    end

    assign o_write_en    = r_write_en;
    assign o_write_addr  = r_write_addr;
    assign o_write_data  = r_write_data;
    assign o_read_en     = r_read_en;
    assign o_read_addr   = r_read_addr;
    assign o_Frame_Error = r_frame_error;
    assign o_Cmd_Error   = r_cmd_error;

endmodule

`default_nettype wire

// File: tb/tb_uart_reg_master.sv
// ============================================================================
// Module      : tb_uart_reg_master
// Description : Self-checking bench for uart_reg_master: directed command
//               table, randomized command streams against a protocol model,
//               and reset/glitch sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_reg_master;

    localparam int CPB = 4;
    localparam int TO  = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       we, re, fe, ce;
    logic [4:0] waddr, raddr;
    logic [7:0] wdata;

    int n_checks = 0;
    int n_err    = 0;

    // pulse monitors (cumulative)
    int n_we = 0, n_re = 0, n_fe = 0, n_ce = 0, n_both = 0, n_wide = 0;
    logic p_we = 1'b0, p_re = 1'b0, p_fe = 1'b0, p_ce = 1'b0;

    // behavioural expectations for the held output registers
    int m_waddr = 0, m_wdata = 0, m_raddr = 0;

    uart_reg_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_UART_RX    (rx),
        .o_write_en   (we),
        .o_write_addr (waddr),
        .o_write_data (wdata),
        .o_read_en    (re),
        .o_read_addr  (raddr),
        .o_Frame_Error(fe),
        .o_Cmd_Error  (ce)
    );

    always #5 clk = ~clk;

    // Count strobe pulses and flag any strobe wider than one cycle
    always @(negedge clk) begin
        if (we) n_we++;
        if (re) n_re++;
        if (fe) n_fe++;
        if (ce) n_ce++;
        if (we && re) n_both++;
        if ((we && p_we) || (re && p_re) || (fe && p_fe) || (ce && p_ce)) n_wide++;
        p_we = we; p_re = re; p_fe = fe; p_ce = ce;
    end

    typedef struct {
        int             n;
        logic [3:0][7:0] b;
        logic [3:0]      ok;
        logic [3:0]      late;
        int e_we, e_re, e_fe, e_ce, e_waddr, e_wdata, e_raddr;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [7:0] b0, b1, b2, b3,
                                input logic [3:0] ok, input logic [3:0] late,
                                input int ewe, ere, efe, ece, ewa, ewd, era);
        vec_t v;
        v.n = n; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.ok = ok; v.late = late;
        v.e_we = ewe; v.e_re = ere; v.e_fe = efe; v.e_ce = ece;
        v.e_waddr = ewa; v.e_wdata = ewd; v.e_raddr = era;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame preceded by gap idle cycles and followed by one idle bit time
    task automatic send_byte(input logic [7:0] d, input logic stop_ok, input int gap);
        tick(gap);
        rx = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i]; tick(CPB);
        end
        rx = stop_ok; tick(CPB);
        rx = 1'b1; tick(CPB);
    endtask

    task automatic run_seq(input int n, input logic [3:0][7:0] b,
                           input logic [3:0] ok, input logic [3:0] late);
        for (int i = 0; i < n; i++)
            send_byte(b[i], ok[i], late[i] ? ((i == 0) ? 101 : $urandom_range(101, 150))
                                           : $urandom_range(0, 20));
        tick(160);
    endtask

    // Protocol-level reference: expected pulse counts for one byte stream
    task automatic model_seq(input int n, input logic [3:0][7:0] b,
                             input logic [3:0] ok, input logic [3:0] late,
                             output int xwe, output int xre, output int xfe, output int xce);
        int mode;   // 0 idle, 1 want write addr, 2 want write data, 3 want read addr
        int lat;
        mode = 0; lat = 0; xwe = 0; xre = 0; xfe = 0; xce = 0;
        for (int i = 0; i < n; i++) begin
            if (mode != 0 && late[i]) begin xce++; mode = 0; end
            if (!ok[i]) begin
                xfe++; mode = 0;
            end else begin
                case (mode)
                    0: mode = (b[i] == 8'hA5) ? 1 : (b[i] == 8'h5A) ? 3 : 0;
                    1: begin
                        if (b[i] > 8'd31) begin xce++; mode = 0; end
                        else begin lat = int'(b[i]); mode = 2; end
                    end
                    2: begin xwe++; m_waddr = lat; m_wdata = int'(b[i]); mode = 0; end
                    default: begin
                        if (b[i] > 8'd31) xce++;
                        else begin xre++; m_raddr = int'(b[i]); end
                        mode = 0;
                    end
                endcase
            end
        end
        if (mode != 0) xce++;
    endtask

    task automatic check_case(input string tag, input int s_we, s_re, s_fe, s_ce,
                              input int xwe, xre, xfe, xce, xwa, xwd, xra);
        check({tag, " write_en pulses"}, n_we - s_we, xwe);
        check({tag, " read_en pulses"},  n_re - s_re, xre);
        check({tag, " frame_err pulses"}, n_fe - s_fe, xfe);
        check({tag, " cmd_err pulses"},  n_ce - s_ce, xce);
        check({tag, " write_addr"}, int'(waddr), xwa);
        check({tag, " write_data"}, int'(wdata), xwd);
        check({tag, " read_addr"},  int'(raddr), xra);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " write_en"},   int'(we), 0);
        check({tag, " read_en"},    int'(re), 0);
        check({tag, " frame_err"},  int'(fe), 0);
        check({tag, " cmd_err"},    int'(ce), 0);
        check({tag, " write_addr"}, int'(waddr), 0);
        check({tag, " write_data"}, int'(wdata), 0);
        check({tag, " read_addr"},  int'(raddr), 0);
    endtask

    vec_t tbl[7];

    initial begin
        int s_we, s_re, s_fe, s_ce, xwe, xre, xfe, xce, n;
        logic [3:0][7:0] b;
        logic [3:0] ok, late;
        int r;

        //                 n  b0     b1     b2     b3     ok       late     we re fe ce wa wd    ra
        tbl[0] = mk(3, 8'hA5, 8'h03, 8'h3C, 8'h00, 4'b1111, 4'b0000, 1, 0, 0, 0, 3, 8'h3C, 0);
        tbl[1] = mk(2, 8'h5A, 8'h1F, 8'h00, 8'h00, 4'b1111, 4'b0000, 0, 1, 0, 0, 3, 8'h3C, 31);
        tbl[2] = mk(3, 8'hA5, 8'h03, 8'h3C, 8'h00, 4'b1110, 4'b0000, 0, 0, 1, 0, 3, 8'h3C, 31);
        tbl[3] = mk(2, 8'hA5, 8'h03, 8'h00, 8'h00, 4'b1111, 4'b0010, 0, 0, 0, 1, 3, 8'h3C, 31);
        tbl[4] = mk(3, 8'hA5, 8'h25, 8'h3C, 8'h00, 4'b1111, 4'b0000, 0, 0, 0, 1, 3, 8'h3C, 31);
        tbl[5] = mk(2, 8'h5A, 8'hA5, 8'h00, 8'h00, 4'b1111, 4'b0000, 0, 0, 0, 1, 3, 8'h3C, 31);
        tbl[6] = mk(3, 8'hA5, 8'h07, 8'h5A, 8'h00, 4'b1111, 4'b0000, 1, 0, 0, 0, 7, 8'h5A, 31);

        // reset state
        tick(5);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(10);

        // directed command table
        for (int k = 0; k < 7; k++) begin
            s_we = n_we; s_re = n_re; s_fe = n_fe; s_ce = n_ce;
            run_seq(tbl[k].n, tbl[k].b, tbl[k].ok, tbl[k].late);
            check_case($sformatf("vec%0d", k), s_we, s_re, s_fe, s_ce,
                       tbl[k].e_we, tbl[k].e_re, tbl[k].e_fe, tbl[k].e_ce,
                       tbl[k].e_waddr, tbl[k].e_wdata, tbl[k].e_raddr);
        end
        m_waddr = 7; m_wdata = 8'h5A; m_raddr = 31;

        // randomized command streams against the protocol model
        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) begin
                r = $urandom_range(0, 5);
                if (i == 0 && $urandom_range(0, 3) != 0) b[i] = ($urandom_range(0, 1) != 0) ? 8'hA5 : 8'h5A;
                else if (r <= 1) b[i] = 8'hA5;
                else if (r == 2) b[i] = 8'h5A;
                else if (r <= 4) b[i] = 8'($urandom_range(0, 31));
                else             b[i] = 8'($urandom);
                ok[i]   = ($urandom_range(0, 9) != 0);
                late[i] = ($urandom_range(0, 7) == 0);
            end
            s_we = n_we; s_re = n_re; s_fe = n_fe; s_ce = n_ce;
            model_seq(n, b, ok, late, xwe, xre, xfe, xce);
            run_seq(n, b, ok, late);
            check_case($sformatf("rand%0d", k), s_we, s_re, s_fe, s_ce,
                       xwe, xre, xfe, xce, m_waddr, m_wdata, m_raddr);
        end

        // glitch, then reset in the middle of a byte
        s_we = n_we; s_re = n_re; s_fe = n_fe; s_ce = n_ce;
        rx = 1'b0; tick(1); rx = 1'b1; tick(10);
        rx = 1'b0; tick(CPB);
        rx = 1'b1; tick(CPB);   // A5 bit0
        rx = 1'b0; tick(CPB);   // bit1
        rx = 1'b1; tick(2);     // mid bit2
        #2 rst = 1'b1;
        tick(2);
        check_reset_outputs("mid-byte reset");
        rx = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(80);
        check("glitch/reset write_en pulses", n_we - s_we, 0);
        check("glitch/reset read_en pulses",  n_re - s_re, 0);
        check("glitch/reset frame_err pulses", n_fe - s_fe, 0);
        check("glitch/reset cmd_err pulses",  n_ce - s_ce, 0);

        // reception resumes normally after reset
        s_we = n_we; s_re = n_re; s_fe = n_fe; s_ce = n_ce;
        b = '0; b[0] = 8'hA5; b[1] = 8'h03; b[2] = 8'h3C;
        run_seq(3, b, 4'b1111, 4'b0000);
        check_case("post-reset write", s_we, s_re, s_fe, s_ce, 1, 0, 0, 0, 3, 8'h3C, 0);

        // global strobe properties
        check("write_en and read_en together", n_both, 0);
        check("strobe wider than one cycle", n_wide, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_reg_master.md
UART_REG_MASTER -- requirements
Module: Uart_Reg_Master

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, giving i_Clk cycles per UART bit (25 MHz / 115200); legal values 4 and above.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 250000, giving the maximum idle cycles allowed between bytes of one command.
REQ-003 SHALL have port i_Clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port i_Reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_UART_RX, input, 1 bit: serial line, 8N1, idle high, asynchronous to i_Clk.
REQ-006 SHALL have port o_write_en, output, 1 bit: one-cycle write strobe to the register-file write port.
REQ-007 SHALL have port o_write_addr, output, 5 bits: write address.
REQ-008 SHALL have port o_write_data, output, 8 bits: write data.
REQ-009 SHALL have port o_read_en, output, 1 bit: one-cycle read strobe.
REQ-010 SHALL have port o_read_addr, output, 5 bits: read address.
REQ-011 SHALL have port o_Frame_Error, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-012 SHALL have port o_Cmd_Error, output, 1 bit: one-cycle pulse on a bad address byte or a timeout abort.

Function
REQ-013 SHALL pass i_UART_RX through a 2-flop synchronizer before any use.
REQ-014 Receiver states SHALL be RX_IDLE, RX_START, RX_DATA and RX_STOP.
REQ-015 In RX_IDLE, a synchronized low level SHALL enter RX_START.
REQ-016 RX_START SHALL wait CLKS_PER_BIT/2 cycles, then re-sample the line; a high level SHALL return to RX_IDLE as a glitch, with no error and no byte.
REQ-017 RX_DATA SHALL sample 8 bits LSB first, each CLKS_PER_BIT cycles after the previous sample.
REQ-018 RX_STOP SHALL sample the stop bit after a further CLKS_PER_BIT cycles.
REQ-019 A high stop bit SHALL raise an internal byte-valid strobe for exactly 1 cycle (the stop-sample cycle) and return to RX_IDLE.
REQ-020 A low stop bit SHALL pulse o_Frame_Error for 1 cycle, discard the byte, and return to RX_IDLE only once the line is high.
REQ-021 Parser states SHALL be CMD_IDLE, CMD_WADDR, CMD_WDATA and CMD_RADDR; transitions occur only on the byte-valid strobe, a frame error, or a timeout.
REQ-022 In CMD_IDLE, byte 0xA5 SHALL go to CMD_WADDR, byte 0x5A SHALL go to CMD_RADDR, and any other byte SHALL be ignored silently.
REQ-023 An address byte with bits [7:5] nonzero SHALL pulse o_Cmd_Error and return to CMD_IDLE, with no strobe.
REQ-024 In CMD_WADDR, a valid address byte SHALL latch bits [4:0] internally and go to CMD_WDATA.
REQ-025 In CMD_WDATA, the data byte SHALL update o_write_addr and o_write_data, and SHALL assert o_write_en for 1 cycle, all on the cycle after the byte-valid strobe; then go to CMD_IDLE.
REQ-026 In CMD_RADDR, a valid address byte SHALL update o_read_addr and assert o_read_en for 1 cycle, on the cycle after the byte-valid strobe; then go to CMD_IDLE.
REQ-027 o_write_addr, o_write_data and o_read_addr SHALL hold their values until the next completed command of the same type.
REQ-028 o_write_en and o_read_en SHALL never be high in the same cycle.
REQ-029 An inter-byte counter SHALL clear on every byte-valid strobe and SHALL count while the parser is not in CMD_IDLE.
REQ-030 When the inter-byte counter reaches TIMEOUT_CLKS, the parser SHALL pulse o_Cmd_Error and return to CMD_IDLE.
REQ-031 A frame error in any parser state SHALL return the parser to CMD_IDLE, with no o_Cmd_Error pulse.
REQ-032 A header byte (0xA5 or 0x5A) received in a non-idle parser state SHALL be treated as address or data, never as a restart.
REQ-033 All counters SHALL be sized to hold CLKS_PER_BIT-1 and TIMEOUT_CLKS without wrap-around.

Reset
REQ-034 While i_Reset is high, both FSMs SHALL be in their idle states, all counters zero, all strobes and error outputs 0, addresses 5'd0 and o_write_data 8'h00.
REQ-035 Reset asserted mid-byte or mid-command SHALL discard the partial byte or command.
REQ-036 After reset release, the first valid start bit SHALL be received normally; a line held low at release SHALL enter RX_START.

Verification (CLKS_PER_BIT=4, TIMEOUT_CLKS=100)
REQ-037 Send bytes A5, 03, 3C -> one o_write_en pulse with o_write_addr=3 and o_write_data=0x3C, the cycle after the third stop-bit sample.
REQ-038 Send bytes 5A, 1F -> one o_read_en pulse with o_read_addr=31; o_write_* unchanged.
REQ-039 Send byte A5 with a low stop bit, then 03, 3C -> one o_Frame_Error pulse; no strobes; the parser stays idle.
REQ-040 Send A5, then idle 101 cycles, then 03 -> o_Cmd_Error pulse at the timeout; the later 03 is ignored; no strobe.
REQ-041 Send A5, 25 -> o_Cmd_Error pulse; the next byte 3C produces no write.
REQ-042 Send a 1-cycle low glitch, then assert i_Reset during the data bits of A5 -> no byte, no error, all outputs at reset values.
